branch_ckpt_ctrl: RTL and testbench

//  Checkpoint (branch-mask) controller for the control-ALU functional unit. Allocates checkpoint IDs
//  to branches at rename, tracks each live branch's older-branch mask, and converts resolutions from
//  the control FU into the registered ctrlVerified/ctrlMispredict/ctrlSMTid broadcast that every FU

---
 rtl/branch_ckpt_ctrl.sv | 174 +++++++++++++++++
 tb/tb_branch_ckpt_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ckpt_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ckpt_ctrl
//   Checkpoint (branch-mask) controller for the control-ALU functional unit.
//   Hands out checkpoint IDs to branches at rename, remembers which older
//   checkpoints were live when each branch was allocated, and turns control-FU
//   resolutions into a one-cycle registered broadcast (ctrlVerified_o /
//   ctrlMispredict_o / ctrlSMTid_o) that all FUs use to squash. A mispredict
//   frees the branch plus every younger checkpoint and holds rename for
//   RECOVER_CYCLES cycles.
//
//   Optional build macro: CTRL_PERF_CNT_EN adds two free-running 32-bit event
//   counters (resolved branches, mispredicted branches).
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   allocReq_i          rename wants one checkpoint this cycle
//   allocAck_o          combinational grant; slot is taken at this edge
//   allocId_o           lowest free checkpoint ID
//   allocMask_o         live-checkpoint mask (branch mask of the new branch)
//   resValid_i          control-FU resolution valid
//   resSMTid_i          checkpoint ID of the resolving branch
//   resBranchMask_i     branch mask carried by the resolving branch
//   resMispredict_i     resolving branch was mispredicted
//   ctrlVerified_o      registered broadcast: a branch resolved
//   ctrlMispredict_o    registered broadcast: it mispredicted
//   ctrlSMTid_o         registered broadcast: its checkpoint ID (holds)
//   freeCount_o         number of free checkpoints
//   recovering_o        FSM is in RECOVER
//   perfResolved_o      (CTRL_PERF_CNT_EN) count of broadcast cycles
//   perfMispredict_o    (CTRL_PERF_CNT_EN) count of mispredict broadcasts
//
// FSM states
//   state   | meaning
//   RUN     | normal operation, allocation allowed
//   RECOVER | post-mispredict hold, allocation blocked until recCnt hits 0
// ---------------------------------------------------------------------------
module branch_ckpt_ctrl #(
  parameter int CHECKPOINTS     = 4,
  parameter int CHECKPOINTS_LOG = 2,
  parameter int RECOVER_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       allocReq_i,
  output logic                       allocAck_o,
  output logic [CHECKPOINTS_LOG-1:0] allocId_o,
  output logic [CHECKPOINTS-1:0]     allocMask_o,
  input  logic                       resValid_i,
  input  logic [CHECKPOINTS_LOG-1:0] resSMTid_i,
  input  logic [CHECKPOINTS-1:0]     resBranchMask_i,
  input  logic                       resMispredict_i,
  output logic                       ctrlVerified_o,
  output logic                       ctrlMispredict_o,
  output logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_o,
  output logic [CHECKPOINTS_LOG:0]   freeCount_o,
  output logic                       recovering_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                perfResolved_o,
  output logic [31:0]                perfMispredict_o
`endif
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  // Down-counter width: must hold RECOVER_CYCLES-1.
  localparam int CNT_W = (RECOVER_CYCLES > 2) ? $clog2(RECOVER_CYCLES) : 1;

  logic [0:0]                 state;
  logic [CNT_W-1:0]           recCnt;
  logic [CHECKPOINTS-1:0]     freeVec;
  logic [CHECKPOINTS-1:0]     depMask [CHECKPOINTS];

  logic                       bcastMisp;
  logic                       resAccept;
  logic [CHECKPOINTS_LOG-1:0] allocIdC;
  logic [CHECKPOINTS-1:0]     grantVec;
  logic [CHECKPOINTS-1:0]     releaseMask;
  logic [CHECKPOINTS_LOG:0]   freeCountC;

  assign bcastMisp = ctrlVerified_o & ctrlMispredict_o;

  // A resolution that the current mispredict broadcast squashes is dropped,
  // exactly as any other FU would drop it.
  assign resAccept = resValid_i & ~(bcastMisp & resBranchMask_i[ctrlSMTid_o]);

  // Lowest free index; 0 when full.
  always_comb begin
    allocIdC = '0;
    for (int i = CHECKPOINTS - 1; i >= 0; i--) begin
      if (freeVec[i]) allocIdC = CHECKPOINTS_LOG'(i);
    end
  end

  assign allocId_o   = allocIdC;
  assign allocMask_o = ~freeVec;
  assign allocAck_o  = allocReq_i & (|freeVec) & (state == RUN) & ~bcastMisp;
  assign grantVec    = allocAck_o ? (CHECKPOINTS'(1) << allocIdC) : '0;

  // Slots released at the edge ending the broadcast cycle. On a mispredict
  // every checkpoint that recorded the branch as older is younger and goes too.
  always_comb begin
    releaseMask = '0;
    if (ctrlVerified_o) begin
      releaseMask[ctrlSMTid_o] = 1'b1;
      if (ctrlMispredict_o) begin
        for (int k = 0; k < CHECKPOINTS; k++) begin
          if (depMask[k][ctrlSMTid_o]) releaseMask[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    freeCountC = '0;
    for (int i = 0; i < CHECKPOINTS; i++) begin
      freeCountC = freeCountC + (CHECKPOINTS_LOG+1)'(freeVec[i]);
    end
  end

  assign freeCount_o  = freeCountC;
  assign recovering_o = (state == RECOVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      freeVec          <= '1;
      state            <= RUN;
      recCnt           <= '0;
      ctrlVerified_o   <= 1'b0;
      ctrlMispredict_o <= 1'b0;
      ctrlSMTid_o      <= '0;
      for (int k = 0; k < CHECKPOINTS; k++) depMask[k] <= '0;
    end else begin
      // Grant uses the pre-edge freeVec, so a slot released this edge is
      // only allocatable next cycle.
      freeVec <= (freeVec | releaseMask) & ~grantVec;

      // A new branch must not inherit bits of checkpoints released at the same
      // edge, otherwise a later reuse of that ID would look older than it.
      for (int k = 0; k < CHECKPOINTS; k++) begin
        if (allocAck_o && (allocIdC == CHECKPOINTS_LOG'(k)))
          depMask[k] <= allocMask_o & ~releaseMask;
        else
          depMask[k] <= depMask[k] & ~releaseMask;
      end

      ctrlVerified_o   <= resAccept;
      ctrlMispredict_o <= resAccept & resMispredict_i;
      if (resAccept) ctrlSMTid_o <= resSMTid_i;

      if (bcastMisp) begin
        state  <= RECOVER;
        recCnt <= CNT_W'(RECOVER_CYCLES - 1);
      end else if (state == RECOVER) begin
        if (recCnt == '0) state <= RUN;
        else              recCnt <= recCnt - 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perfResolved_o   <= '0;
      perfMispredict_o <= '0;
    end else begin
      if (ctrlVerified_o) perfResolved_o   <= perfResolved_o + 32'd1;
      if (bcastMisp)      perfMispredict_o <= perfMispredict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
module tb_branch_ckpt_ctrl;

  typedef struct packed {
    logic       ack;
    logic [1:0] id;
    logic [3:0] mask;
  } allocExp_t;

  typedef struct packed {
    logic       misp;
    logic [1:0] id;
  } bcastExp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       allocReq;
  logic       allocAck;
  logic [1:0] allocId;
  logic [3:0] allocMask;
  logic       resValid;
  logic [1:0] resId;
  logic [3:0] resMask;
  logic       resMisp;
  logic       ctrlVerified;
  logic       ctrlMispredict;
  logic [1:0] ctrlSMTid;
  logic [2:0] freeCount;
  logic       recovering;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perfResolved;
  logic [31:0] perfMispredict;
`endif

  int total = 0;
  int bad   = 0;

  allocExp_t allocQ[$];
  bcastExp_t bcastQ[$];

  always #5 clk = ~clk;

  branch_ckpt_ctrl #(.CHECKPOINTS(4), .CHECKPOINTS_LOG(2), .RECOVER_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .allocReq_i       (allocReq),
    .allocAck_o       (allocAck),
    .allocId_o        (allocId),
    .allocMask_o      (allocMask),
    .resValid_i       (resValid),
    .resSMTid_i       (resId),
    .resBranchMask_i  (resMask),
    .resMispredict_i  (resMisp),
    .ctrlVerified_o   (ctrlVerified),
    .ctrlMispredict_o (ctrlMispredict),
    .ctrlSMTid_o      (ctrlSMTid),
    .freeCount_o      (freeCount),
    .recovering_o     (recovering)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perfResolved_o   (perfResolved),
    .perfMispredict_o (perfMispredict)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expAlloc(input logic ack, input logic [1:0] id, input logic [3:0] mask);
    allocExp_t e;
    e.ack  = ack;
    e.id   = id;
    e.mask = mask;
    allocQ.push_back(e);
  endtask

  task automatic expBcast(input logic misp, input logic [1:0] id);
    bcastExp_t e;
    e.misp = misp;
    e.id   = id;
    bcastQ.push_back(e);
  endtask

  task automatic resolve(input logic [1:0] id, input logic [3:0] mask, input logic misp);
    resValid = 1'b1;
    resId    = id;
    resMask  = mask;
    resMisp  = misp;
  endtask

  // Reset, then fill all four checkpoints: IDs 0..3 with masks 0000,0001,0011,0111.
  task automatic resetAndFill();
    reset    = 1'b1;
    allocReq = 1'b0;
    resValid = 1'b0;
    resMisp  = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      allocReq = 1'b1;
      expAlloc(1'b1, 2'(i), 4'((1 << i) - 1));
    end
    step();
    allocReq = 1'b0;
  endtask

  // Scoreboard monitor: compares whenever the DUT presents a grant response
  // or a broadcast.
  initial begin
    allocExp_t ea;
    bcastExp_t eb;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (allocReq) begin
          if (allocQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL alloc_unexpected: got ack=%0b id=%0d with no expectation", allocAck, allocId);
          end else begin
            ea = allocQ.pop_front();
            chk("allocAck", 32'(allocAck), 32'(ea.ack));
            chk("allocId", 32'(allocId), 32'(ea.id));
            chk("allocMask", 32'(allocMask), 32'(ea.mask));
          end
        end
        if (ctrlVerified) begin
          if (bcastQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bcast_unexpected: got id=%0d misp=%0b required none", ctrlSMTid, ctrlMispredict);
          end else begin
            eb = bcastQ.pop_front();
            chk("ctrlMispredict", 32'(ctrlMispredict), 32'(eb.misp));
            chk("ctrlSMTid", 32'(ctrlSMTid), 32'(eb.id));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    allocReq = 1'b0;
    resValid = 1'b0;
    resId    = '0;
    resMask  = '0;
    resMisp  = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_freeCount", 32'(freeCount), 32'd4);
    chk("rst_recovering", 32'(recovering), 32'd0);
    chk("rst_ctrlVerified", 32'(ctrlVerified), 32'd0);
    chk("rst_ctrlMispredict", 32'(ctrlMispredict), 32'd0);
    chk("rst_ctrlSMTid", 32'(ctrlSMTid), 32'd0);
    chk("rst_allocAck", 32'(allocAck), 32'd0);

    // Fill: IDs 0..3, then full
    for (int i = 0; i < 4; i++) begin
      step();
      allocReq = 1'b1;
      expAlloc(1'b1, 2'(i), 4'((1 << i) - 1));
    end
    step();
    expAlloc(1'b0, 2'd0, 4'b1111);
    @(negedge clk);
    chk("full_freeCount", 32'(freeCount), 32'd0);
    step();
    allocReq = 1'b0;

    // Correct resolve of ID1
    step();
    resolve(2'd1, 4'b0001, 1'b0);
    expBcast(1'b0, 2'd1);
    step();
    resValid = 1'b0;
    @(negedge clk);
    chk("ok_freeCount_T1", 32'(freeCount), 32'd0);
    step();
    allocReq = 1'b1;
    expAlloc(1'b1, 2'd1, 4'b1101);
    @(negedge clk);
    chk("ok_freeCount_T2", 32'(freeCount), 32'd1);
    chk("ok_verified_T2", 32'(ctrlVerified), 32'd0);
    chk("ok_smtid_hold_T2", 32'(ctrlSMTid), 32'd1);
    step();
    allocReq = 1'b0;

    // Mispredict ID1 frees 1,2,3 and blocks allocation for the recover window
    resetAndFill();
    step();
    resolve(2'd1, 4'b0001, 1'b1);
    expBcast(1'b1, 2'd1);
    step();
    resValid = 1'b0;
    allocReq = 1'b1;
    expAlloc(1'b0, 2'd0, 4'b1111);
    @(negedge clk);
    chk("mp_recovering_T1", 32'(recovering), 32'd0);
    step();
    expAlloc(1'b0, 2'd1, 4'b0001);
    @(negedge clk);
    chk("mp_freeCount_T2", 32'(freeCount), 32'd3);
    chk("mp_recovering_T2", 32'(recovering), 32'd1);
    step();
    expAlloc(1'b0, 2'd1, 4'b0001);
    @(negedge clk);
    chk("mp_recovering_T3", 32'(recovering), 32'd1);
    step();
    expAlloc(1'b1, 2'd1, 4'b0001);
    @(negedge clk);
    chk("mp_recovering_T4", 32'(recovering), 32'd0);
    step();
    allocReq = 1'b0;

    // Resolution of ID2 squashed by mispredict broadcast of ID0 is dropped
    resetAndFill();
    step();
    resolve(2'd0, 4'b0000, 1'b1);
    expBcast(1'b1, 2'd0);
    step();
    resolve(2'd2, 4'b0011, 1'b0);
    step();
    resValid = 1'b0;
    @(negedge clk);
    chk("drop_verified", 32'(ctrlVerified), 32'd0);
    chk("drop_freeCount", 32'(freeCount), 32'd4);
    chk("drop_recovering", 32'(recovering), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("drop_recovering_end", 32'(recovering), 32'd0);

    // Older mispredict during a younger one's broadcast is accepted and reloads the counter
    resetAndFill();
    step();
    resolve(2'd2, 4'b0011, 1'b1);
    expBcast(1'b1, 2'd2);
    step();
    resolve(2'd1, 4'b0001, 1'b1);
    expBcast(1'b1, 2'd1);
    step();
    resValid = 1'b0;
    @(negedge clk);
    chk("reload_recovering_T2", 32'(recovering), 32'd1);
    chk("reload_freeCount_T2", 32'(freeCount), 32'd2);
    step();
    @(negedge clk);
    chk("reload_recovering_T3", 32'(recovering), 32'd1);
    chk("reload_freeCount_T3", 32'(freeCount), 32'd3);
    step();
    allocReq = 1'b1;
    expAlloc(1'b0, 2'd1, 4'b0001);
    @(negedge clk);
    chk("reload_recovering_T4", 32'(recovering), 32'd1);
    step();
    expAlloc(1'b1, 2'd1, 4'b0001);
    @(negedge clk);
    chk("reload_recovering_T5", 32'(recovering), 32'd0);
    step();
    allocReq = 1'b0;

    // Full: alloc request coinciding with correct-resolve broadcast of ID3
    resetAndFill();
    step();
    resolve(2'd3, 4'b0111, 1'b0);
    allocReq = 1'b1;
    expBcast(1'b0, 2'd3);
    expAlloc(1'b0, 2'd0, 4'b1111);
    step();
    resValid = 1'b0;
    expAlloc(1'b0, 2'd0, 4'b1111);
    @(negedge clk);
    chk("same_freeCount_T1", 32'(freeCount), 32'd0);
    step();
    expAlloc(1'b1, 2'd3, 4'b0111);
    @(negedge clk);
    chk("same_freeCount_T2", 32'(freeCount), 32'd1);
    step();
    allocReq = 1'b0;
    @(negedge clk);
    chk("same_freeCount_T3", 32'(freeCount), 32'd0);

    // Reset while recovering
    step();
    resolve(2'd1, 4'b0001, 1'b1);
    expBcast(1'b1, 2'd1);
    step();
    resValid = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_recovering_pre", 32'(recovering), 32'd1);
    chk("rr_smtid_pre", 32'(ctrlSMTid), 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rr_recovering", 32'(recovering), 32'd0);
    chk("rr_freeCount", 32'(freeCount), 32'd4);
    chk("rr_ctrlVerified", 32'(ctrlVerified), 32'd0);
    chk("rr_ctrlMispredict", 32'(ctrlMispredict), 32'd0);
    chk("rr_ctrlSMTid", 32'(ctrlSMTid), 32'd0);

    step();
    @(negedge clk);
    chk("allocQ_drained", 32'(allocQ.size()), 32'd0);
    chk("bcastQ_drained", 32'(bcastQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
